// File: rtl/if_id_stage_buffer.sv
// IF/ID stage: 2-entry skid buffer between fetch and decode.
// Presents the head word pre-split into MIPS fields.
module if_id_stage_buffer #(
  parameter logic [31:0] NOP_INSTRUCTION = 32'h00000000,
  parameter logic [31:0] RESET_PC        = 32'h00000000
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic [31:0] fetch_instruction,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic        flush,
  input  logic        decode_ready,
  output logic        decode_valid,
  output logic [31:0] decode_instruction,
  output logic [31:0] decode_pc,
  output logic [31:0] decode_pc_plus_4,
  output logic [5:0]  decode_opcode,
  output logic [4:0]  decode_rs,
  output logic [4:0]  decode_rt,
  output logic [4:0]  decode_rd,
  output logic [4:0]  decode_shamt,
  output logic [5:0]  decode_funct,
  output logic [31:0] decode_imm_sext,
  output logic [31:0] decode_imm_zext,
  output logic [31:0] decode_jump_target,
  output logic [31:0] issued_count
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  logic [31:0] issued_q, issued_d;

  logic   push;
  logic   pop;
  entry_t in_e;

  assign in_e = '{instr: fetch_instruction, pc: fetch_pc};

  // Handshakes depend only on registered state, never on decode_ready.
  assign fetch_ready  = (state_q != FULL);
  assign decode_valid = (state_q != EMPTY);
  assign push = fetch_valid && fetch_ready && !flush;
  assign pop  = decode_valid && decode_ready && !flush;

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      state_q  <= EMPTY;
      head_q   <= '0;
      tail_q   <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      issued_q <= issued_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    tail_d   = tail_q;
    issued_d = issued_q + {31'd0, pop};
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            head_d  = in_e;
          end
        end
        ONE: begin
          unique case (1'b1)
            push && pop: head_d = in_e;
            push && !pop: begin
              state_d = FULL;
              tail_d  = in_e;
            end
            !push && pop: state_d = EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            head_d  = tail_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  logic [31:0] instr;
  logic [31:0] pc;

  always_comb begin
    instr = NOP_INSTRUCTION;
    pc    = RESET_PC;
    if (decode_valid) begin
      instr = head_q.instr;
      pc    = head_q.pc;
    end
  end

  assign decode_instruction = instr;
  assign decode_pc          = pc;
  assign decode_pc_plus_4   = pc + 32'd4;
  assign decode_opcode      = instr[31:26];
  assign decode_rs          = instr[25:21];
  assign decode_rt          = instr[20:16];
  assign decode_rd          = instr[15:11];
  assign decode_shamt       = instr[10:6];
  assign decode_funct       = instr[5:0];
  assign decode_imm_sext    = {{16{instr[15]}}, instr[15:0]};
  assign decode_imm_zext    = {16'd0, instr[15:0]};
  assign decode_jump_target =
    {decode_pc_plus_4[31:28], instr[25:0], 2'b00};
  assign issued_count       = issued_q;

endmodule

// File: doc/if_id_stage_buffer.md
Name: if_id_stage_buffer

Overview:
- Pipeline stage between the instruction fetch unit and instruction decode.
- Captures each fetched instruction with its PC in a 2-entry skid buffer, so a decode stall never drops a word already in flight from the 1-cycle-latency instruction memory.
- Supports synchronous flush for branch/jump redirects.
- Presents the head instruction to decode, pre-split into MIPS fields, with extended immediates and a jump target.

Parameters:
- NOP_INSTRUCTION, 32'h00000000, word driven on decode_instruction when the buffer is empty (sll $0,$0,0).
- RESET_PC, 32'h00000000, value driven on decode_pc when the buffer is empty.

Ports:
- system_clock  input  1  stage clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_instruction  input  32  instruction word from fetch.
- fetch_pc  input  32  byte address of fetch_instruction.
- fetch_valid  input  1  fetch_instruction/fetch_pc are valid this cycle.
- fetch_ready  output  1  buffer can accept a word this cycle.
- flush  input  1  discard all buffered and incoming words.
- decode_ready  input  1  decode consumes the head entry this cycle (low = stall).
- decode_valid  output  1  head entry is valid.
- decode_instruction  output  32  head instruction word.
- decode_pc  output  32  head PC.
- decode_pc_plus_4  output  32  decode_pc + 4, modulo 2^32.
- decode_opcode  output  6  instr[31:26].
- decode_rs  output  5  instr[25:21].
- decode_rt  output  5  instr[20:16].
- decode_rd  output  5  instr[15:11].
- decode_shamt  output  5  instr[10:6].
- decode_funct  output  6  instr[5:0].
- decode_imm_sext  output  32  sign-extended instr[15:0].
- decode_imm_zext  output  32  zero-extended instr[15:0].
- decode_jump_target  output  32  {decode_pc_plus_4[31:28], instr[25:0], 2'b00}.
- issued_count  output  32  number of entries consumed by decode since reset.

Behaviour:
- State: two entries (head, tail), each holding {instruction, pc}, plus an occupancy count of 0/1/2 (EMPTY/ONE/FULL).
- Reset (asynchronous, reset low):
  - count = EMPTY, issued_count = 0, entry contents cleared.
  - Outputs during and after reset: decode_valid=0, decode_instruction=NOP_INSTRUCTION, decode_pc=RESET_PC, fetch_ready=1.
  - All field outputs are derived from those values.
- fetch_ready = (count != FULL). It is a function of registered state only, with no combinational path from decode_ready.
- push = fetch_valid && fetch_ready && !flush.
- pop = decode_valid && decode_ready && !flush.
- Transitions:
  - EMPTY: push -> ONE (word goes to head).
  - ONE:
    - push && !pop -> FULL (word goes to tail).
    - push && pop -> ONE (new word becomes head).
    - pop only -> EMPTY.
  - FULL (push is impossible here):
    - pop -> ONE (tail shifts to head).
- Ordering: strict FIFO; words reach decode in push order.
- Latency: a word pushed at edge N is on the decode outputs after edge N, i.e. in cycle N+1, when the buffer was EMPTY.
- Flush:
  - flush high at an edge -> count = EMPTY, and any simultaneous fetch_valid word is discarded.
  - issued_count is not incremented on that edge, even if decode_ready is high.
  - Flush has priority over push and pop.
  - Flush while already EMPTY is a no-op.
- Empty outputs: decode_valid=0, decode_instruction=NOP_INSTRUCTION, decode_pc=RESET_PC, fields derived from those values.
- Fields are combinational from the head entry.
- Width and arithmetic:
  - decode_pc_plus_4 wraps at 2^32.
  - issued_count increments by 1 on each pop and wraps from 32'hFFFFFFFF to 0.
- fetch_valid while fetch_ready=0: the word is ignored; fetch is responsible for holding it.
- decode_ready while EMPTY: no effect.

Test Plan:
- Reset: assert reset mid-operation with count=FULL -> immediately decode_valid=0, decode_instruction=32'h0, fetch_ready=1, issued_count=0.
- Streaming: push 0x8C010004 at PC 0x0, then 0x00221820 at PC 0x4, with decode_ready=1 throughout.
  - Each appears one cycle after its push.
  - For the second word: decode_rd=3, decode_funct=0x20, decode_pc_plus_4=0x8.
  - issued_count=2 afterwards.
- Stall/skid: decode_ready=0, push words A then B.
  - Count reaches FULL, fetch_ready=0, and word C offered is ignored.
  - Raise decode_ready -> A, then B, then empty; C is never seen.
- Flush priority: count=FULL, assert flush with fetch_valid=1 (word D) and decode_ready=1.
  - Next cycle decode_valid=0.
  - D is dropped.
  - issued_count is unchanged.
- Field extension: head 0x2001FFFC (addi) -> decode_imm_sext=0xFFFFFFFC, decode_imm_zext=0x0000FFFC, decode_rt=1.
- Wrap: head 0x08000010 at PC 0xFFFFFFFC -> decode_pc_plus_4=0x00000000, decode_jump_target=0x00000040.
  - Separately, preload issued_count near 2^32-1 via a sequence of pops and confirm it wraps to 0.
